// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order tracker for conditional branches between fetch
// and execute. It stores the predicted direction, the 4-bit predictor index and
// the alternate-path PC for each branch. On resolution it emits a one-cycle
// predictor training pulse. On a misprediction it emits a one-cycle flush with
// the redirect PC, and it discards every queued entry.
// Optional feature: define BRQ_STATS_EN to add saturating branch and mispredict
// counters (o_stat_branches, o_stat_mispredicts).
// Instruction bits are numbered MSB-first in the architectural description.
// Architectural bits 0..5 (opcode) map to [31:26]. Bits 28..31 (index) map to [3:0].

module branch_resolve_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_valid,
    input  logic [31:0] i_fetch_instr,
    input  logic        i_fetch_pred,
    input  logic [31:0] i_fetch_alt_pc,
    input  logic        i_resolve_valid,
    input  logic        i_resolve_taken,
    output logic        o_stall,
    output logic        o_update_valid,
    output logic [3:0]  o_update_index,
    output logic [1:0]  o_pred_actual,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc,
`ifdef BRQ_STATS_EN
    output logic [15:0] o_stat_branches,
    output logic [15:0] o_stat_mispredicts,
`endif
    output logic        o_underflow
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic        pred;
        logic [3:0]  idx;
        logic [31:0] alt_pc;
    } brq_entry_t;

    brq_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic       w_is_branch;
    logic       w_pop;
    logic       w_mispredict;
    logic       w_push;
    logic       w_empty_resolve;
    brq_entry_t w_head;
    logic       w_unused_instr;

    // Only the opcode and the predictor index fields of the instruction are used.
    assign w_unused_instr = ^i_fetch_instr[25:4];

    // Decode the branch. Mispredict discards the same-cycle push, which is wrong-path.
    assign w_is_branch     = i_fetch_valid &&
                             ((i_fetch_instr[31:26] == 6'b100010) ||
                              (i_fetch_instr[31:26] == 6'b100011));
    assign w_head          = r_mem[r_rd_ptr];
    assign w_pop           = i_resolve_valid && (r_count != '0);
    assign w_empty_resolve = i_resolve_valid && (r_count == '0);
    assign w_mispredict    = w_pop && (w_head.pred != i_resolve_taken);
    assign w_push          = w_is_branch && (r_count != CNT_FULL) && !w_mispredict;
    assign o_stall         = (r_count == CNT_FULL);

    // Entry storage. It is not reset because count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{pred: i_fetch_pred, idx: i_fetch_instr[3:0],
                                 alt_pc: i_fetch_alt_pc};
        end
    end

    // Update the pointers and the count. A mispredict empties the queue by aligning the read pointer to the write pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_mispredict) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Register the training pulse, the flush and the redirect PC, plus the sticky underflow flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_update_valid <= 1'b0;
            o_update_index <= 4'd0;
            o_pred_actual  <= 2'b00;
            o_flush        <= 1'b0;
            o_redirect_pc  <= 32'd0;
            o_underflow    <= 1'b0;
        end else begin
            o_update_valid <= w_pop;
            o_update_index <= w_pop ? w_head.idx : 4'd0;
            o_pred_actual  <= w_pop ? {w_head.pred, i_resolve_taken} : 2'b00;
            o_flush        <= w_mispredict;
            o_redirect_pc  <= w_mispredict ? w_head.alt_pc : 32'd0;
            o_underflow    <= o_underflow | w_empty_resolve;
        end
    end

`ifdef BRQ_STATS_EN
    // Saturating counters for resolved branches and for mispredicted branches.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stat_branches    <= 16'd0;
            o_stat_mispredicts <= 16'd0;
        end else begin
            if (w_pop && (o_stat_branches != 16'hFFFF)) begin
                o_stat_branches <= o_stat_branches + 16'd1;
            end
            if (w_mispredict && (o_stat_mispredicts != 16'hFFFF)) begin
                o_stat_mispredicts <= o_stat_mispredicts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue. The reference model is an in-order
// queue of entries. Directed scenarios run first, followed by randomized traffic
// with occasional asynchronous resets.

module tb_branch_resolve_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PTR_W = 2;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        fetch_pred;
    logic [31:0] fetch_alt_pc;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        stall;
    logic        update_valid;
    logic [3:0]  update_index;
    logic [1:0]  pred_actual;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        underflow;
`ifdef BRQ_STATS_EN
    logic [15:0] stat_branches;
    logic [15:0] stat_mispredicts;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef struct {
        bit        pred;
        bit [3:0]  idx;
        bit [31:0] alt;
    } ent_t;

    ent_t      mq[$];
    bit        e_uv;
    bit [3:0]  e_idx;
    bit [1:0]  e_pa;
    bit        e_fl;
    bit [31:0] e_rpc;
    bit        e_un;
    int unsigned e_sb;
    int unsigned e_sm;

    branch_resolve_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_fetch_valid   (fetch_valid),
        .i_fetch_instr   (fetch_instr),
        .i_fetch_pred    (fetch_pred),
        .i_fetch_alt_pc  (fetch_alt_pc),
        .i_resolve_valid (resolve_valid),
        .i_resolve_taken (resolve_taken),
        .o_stall         (stall),
        .o_update_valid  (update_valid),
        .o_update_index  (update_index),
        .o_pred_actual   (pred_actual),
        .o_flush         (flush),
        .o_redirect_pc   (redirect_pc),
`ifdef BRQ_STATS_EN
        .o_stat_branches    (stat_branches),
        .o_stat_mispredicts (stat_mispredicts),
`endif
        .o_underflow     (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        e_uv = 0; e_idx = 0; e_pa = 0; e_fl = 0; e_rpc = 0; e_un = 0;
        e_sb = 0; e_sm = 0;
    endtask

    task automatic check_all();
        chk("stall", 32'(stall), 32'(mq.size() == DEPTH));
        chk("update_valid", 32'(update_valid), 32'(e_uv));
        if (e_uv) chk("update_index", 32'(update_index), 32'(e_idx));
        chk("pred_actual", 32'(pred_actual), 32'(e_pa));
        chk("flush", 32'(flush), 32'(e_fl));
        chk("redirect_pc", redirect_pc, e_rpc);
        chk("underflow", 32'(underflow), 32'(e_un));
`ifdef BRQ_STATS_EN
        chk("stat_branches", 32'(stat_branches), e_sb);
        chk("stat_mispredicts", 32'(stat_mispredicts), e_sm);
`endif
    endtask

    // Model the architectural effect of one clock edge with the given inputs.
    task automatic model_step(input bit fv, input bit [31:0] ins, input bit pr,
                              input bit [31:0] alt, input bit rv, input bit rt);
        bit   is_br;
        bit   full;
        bit   mis;
        ent_t h;
        ent_t n;
        is_br = fv && (ins[31:26] == 6'b100010 || ins[31:26] == 6'b100011);
        full  = (mq.size() == DEPTH);
        mis   = 0;
        e_uv = 0; e_idx = 0; e_pa = 0; e_fl = 0; e_rpc = 0;
        if (rv) begin
            if (mq.size() == 0) begin
                e_un = 1;
            end else begin
                h = mq.pop_front();
                e_uv = 1; e_idx = h.idx; e_pa = {h.pred, rt};
                if (e_sb < 16'hFFFF) e_sb++;
                if (h.pred != rt) begin
                    mis = 1; e_fl = 1; e_rpc = h.alt;
                    if (e_sm < 16'hFFFF) e_sm++;
                    mq.delete();
                end
            end
        end
        if (is_br && !full && !mis) begin
            n.pred = pr; n.idx = ins[3:0]; n.alt = alt;
            mq.push_back(n);
        end
    endtask

    // Drive one cycle from a negedge, advance through posedge, then check at the next negedge.
    task automatic cyc(input bit fv, input bit [31:0] ins, input bit pr,
                       input bit [31:0] alt, input bit rv, input bit rt);
        fetch_valid = fv; fetch_instr = ins; fetch_pred = pr; fetch_alt_pc = alt;
        resolve_valid = rv; resolve_taken = rt;
        model_step(fv, ins, pr, alt, rv, rt);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    function automatic bit [31:0] mk_br(input bit [3:0] idx);
        bit [31:0] v;
        v = $urandom();
        v[31:26] = ($urandom_range(0, 1) == 1) ? 6'b100011 : 6'b100010;
        v[3:0] = idx;
        return v;
    endfunction

    function automatic bit [31:0] mk_nonbr();
        bit [31:0] v;
        v = $urandom();
        if (v[31:27] == 5'b10001) v[31:26] = 6'b000000;
        return v;
    endfunction

    task automatic idle();
        cyc(0, 32'd0, 0, 32'd0, 0, 0);
    endtask

    task automatic push(input bit [3:0] idx, input bit pr, input bit [31:0] alt);
        cyc(1, mk_br(idx), pr, alt, 0, 0);
    endtask

    task automatic resolve(input bit rt);
        cyc(0, 32'd0, 0, 32'd0, 1, rt);
    endtask

    task automatic async_reset_check();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        fetch_valid = 0; fetch_instr = 0; fetch_pred = 0; fetch_alt_pc = 0;
        resolve_valid = 0; resolve_taken = 0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all();
        chk("rst_update_index", 32'(update_index), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Correct taken prediction trains the predictor with code 11.
        cyc(1, 32'h8800_0005, 1, 32'h100, 0, 0);
        resolve(1);
        chk("t1_index", 32'(update_index), 32'd5);
        chk("t1_pa", 32'(pred_actual), 32'd3);

        // A mispredict flushes the pipeline with the alternate PC.
        push(4'd3, 0, 32'h2C);
        resolve(1);
        chk("t2_redirect", redirect_pc, 32'h2C);
        chk("t2_pa", 32'(pred_actual), 32'd1);
        idle();

        // Fill the queue, drop one extra push, then drain it in order.
        for (int i = 0; i < 4; i++) push(4'(i + 8), 1, 32'(i));
        chk("full_stall", 32'(stall), 32'd1);
        push(4'd15, 1, 32'hDEAD);
        for (int i = 0; i < 4; i++) resolve(1);
        idle();

        // Mispredict on the oldest entry while a new branch pushes in the same cycle.
        push(4'd1, 0, 32'h40);
        push(4'd2, 0, 32'h50);
        cyc(1, mk_br(4'd7), 0, 32'h60, 1, 1);
        resolve(0);
        resolve(0);
        chk("t4_underflow", 32'(underflow), 32'd1);

        // A non-branch opcode leaves the queue untouched.
        cyc(1, 32'h0000_0009, 1, 32'h70, 0, 0);
        resolve(1);

        // Assert reset mid-stream with three entries queued.
        for (int i = 0; i < 3; i++) push(4'(i), 1, 32'h80 + 32'(i));
        async_reset_check();

        // Three pops with one mispredict give stats of 3 and 1.
        push(4'd4, 1, 32'h90);
        push(4'd5, 0, 32'h94);
        resolve(1);
        resolve(0);
        push(4'd6, 1, 32'h98);
        resolve(0);
`ifdef BRQ_STATS_EN
        chk("stat_br_3", 32'(stat_branches), 32'd3);
        chk("stat_mis_1", 32'(stat_mispredicts), 32'd1);
`endif
        idle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset_check();
            end else begin
                bit        fv;
                bit [31:0] ins;
                fv  = ($urandom_range(0, 99) < 65);
                ins = ($urandom_range(0, 99) < 75) ? mk_br(4'($urandom())) : mk_nonbr();
                cyc(fv, ins, 1'($urandom()), $urandom(),
                    ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 60));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
